// File: rtl/prim_rec_node_p.sv
// prim_rec_node_p -- primitive-recursion operator node.
//   f(x,0)   = g(x)
//   f(x,y+1) = h(x, y, f(x,y))
// Handshakes with a parent through ST/RD and with two child operator nodes
// (g, h) through their own start/ready pairs. Ready signals are edge-based:
// only a 0->1 transition on ST, G_RD or H_RD is treated as an event.
// Optional feature: define PRIM_REC_TIMEOUT_EN to add parameter TIMEOUT and
// output ERR. A child that does not answer within TIMEOUT cycles makes the
// node abort with RES=0 and ERR=1.
module prim_rec_node_p #(
   parameter int WIDTH   = 16,
   parameter int NARGS   = 2,
   parameter int REC_IDX = NARGS - 1,
   parameter int CNT_W   = 16
`ifdef PRIM_REC_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 65535
`endif
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   ST,
   input  logic [NARGS*WIDTH-1:0] ARGS,
   output logic                   RD,
   output logic [WIDTH-1:0]       RES,
   output logic                   G_ST,
   input  logic                   G_RD,
   input  logic [WIDTH-1:0]       G_RES,
   output logic                   H_ST,
   input  logic                   H_RD,
   input  logic [WIDTH-1:0]       H_RES,
   output logic [NARGS*WIDTH-1:0] H_ARGS,
   output logic [WIDTH-1:0]       H_ACC
`ifdef PRIM_REC_TIMEOUT_EN
   ,
   output logic                   ERR
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      G_RUN = 2'd1,
      H_RUN = 2'd2
   } state_t;

   state_t                        state, state_d;

   // Arguments latched at start; slot REC_IDX holds y.
   logic [NARGS-1:0][WIDTH-1:0]   args_q;
   logic [CNT_W-1:0]              cnt;
   logic [CNT_W-1:0]              cnt_nxt;
   logic [CNT_W-1:0]              y_ext;

   // Previous-cycle levels for edge detection.
   logic                          st_q, g_rd_q, h_rd_q;
   logic                          st_edge, g_edge, h_edge;

   // Decisions made by the next-state logic, applied by the register block.
   logic                          start_g, start_h;
   logic                          done;
   logic [WIDTH-1:0]              res_d;
   logic                          acc_ld;
   logic [WIDTH-1:0]              acc_d;
   logic                          cnt_inc;
   logic                          tmo_hit;

   assign st_edge = ST   & ~st_q;
   assign g_edge  = G_RD & ~g_rd_q;
   assign h_edge  = H_RD & ~h_rd_q;

   assign cnt_nxt = cnt + CNT_W'(1);
   assign y_ext   = CNT_W'(args_q[REC_IDX]);

   // h sees the latched arguments with the recursion slot replaced by the
   // current iteration index.
   for (genvar k = 0; k < NARGS; k++) begin : g_hargs
      if (k == REC_IDX) begin : g_rec
         assign H_ARGS[k*WIDTH +: WIDTH] = cnt[WIDTH-1:0];
      end else begin : g_pass
         assign H_ARGS[k*WIDTH +: WIDTH] = args_q[k];
      end
   end

`ifdef PRIM_REC_TIMEOUT_EN
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [TW-1:0] tmo_cnt;
   logic          err_set;

   // tmo_cnt counts cycles spent waiting on the current child; it restarts
   // with every child start pulse, so hitting TIMEOUT-1 here means TIMEOUT
   // cycles have elapsed since that pulse.
   assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   // Next-state and per-cycle control decisions.
   always_comb begin
      state_d = state;
      start_g = 1'b0;
      start_h = 1'b0;
      done    = 1'b0;
      res_d   = '0;
      acc_ld  = 1'b0;
      acc_d   = '0;
      cnt_inc = 1'b0;
`ifdef PRIM_REC_TIMEOUT_EN
      err_set = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (st_edge) begin
               start_g = 1'b1;
               state_d = G_RUN;
            end
         end
         G_RUN: begin
            if (g_edge) begin
               acc_ld = 1'b1;
               acc_d  = G_RES;
               if (args_q[REC_IDX] == '0) begin
                  done    = 1'b1;
                  res_d   = G_RES;
                  state_d = IDLE;
               end else begin
                  start_h = 1'b1;
                  state_d = H_RUN;
               end
            end else if (tmo_hit) begin
               done    = 1'b1;
               state_d = IDLE;
`ifdef PRIM_REC_TIMEOUT_EN
               err_set = 1'b1;
`endif
            end
         end
         H_RUN: begin
            if (h_edge) begin
               acc_ld  = 1'b1;
               acc_d   = H_RES;
               cnt_inc = 1'b1;
               if (cnt_nxt == y_ext) begin
                  done    = 1'b1;
                  res_d   = H_RES;
                  state_d = IDLE;
               end else begin
                  start_h = 1'b1;
               end
            end else if (tmo_hit) begin
               done    = 1'b1;
               state_d = IDLE;
`ifdef PRIM_REC_TIMEOUT_EN
               err_set = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state  <= IDLE;
         st_q   <= 1'b0;
         g_rd_q <= 1'b0;
         h_rd_q <= 1'b0;
         args_q <= '0;
         cnt    <= '0;
         RD     <= 1'b1;
         RES    <= '0;
         G_ST   <= 1'b0;
         H_ST   <= 1'b0;
         H_ACC  <= '0;
      end else begin
         state  <= state_d;
         st_q   <= ST;
         g_rd_q <= G_RD;
         h_rd_q <= H_RD;
         G_ST   <= start_g;
         H_ST   <= start_h;
         if (start_g) begin
            args_q <= ARGS;
            cnt    <= '0;
            RD     <= 1'b0;
         end
         if (cnt_inc)
            cnt <= cnt_nxt;
         if (acc_ld)
            H_ACC <= acc_d;
         if (done) begin
            RES <= res_d;
            RD  <= 1'b1;
         end
      end
   end

`ifdef PRIM_REC_TIMEOUT_EN
   // Child-wait watchdog and sticky error flag (cleared by the next start).
   always_ff @(posedge CLK) begin
      if (!RST) begin
         tmo_cnt <= '0;
         ERR     <= 1'b0;
      end else begin
         if (start_g || start_h)
            tmo_cnt <= '0;
         else if (state != IDLE)
            tmo_cnt <= tmo_cnt + TW'(1);
         if (start_g)
            ERR <= 1'b0;
         else if (err_set)
            ERR <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_prim_rec_node_p.sv
// Bench for prim_rec_node_p (WIDTH=16, NARGS=2, y in slot 1).
// Behavioural g/h children respond on the falling edge; each run pushes a
// reference result to a queue that is popped when RD returns high.
module tb_prim_rec_node_p;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        ST  = 1'b0;
   logic [31:0] ARGS = '0;
   logic        RD;
   logic [15:0] RES;
   logic        G_ST;
   logic        G_RD = 1'b1;
   logic [15:0] G_RES = '0;
   logic        H_ST;
   logic        H_RD = 1'b1;
   logic [15:0] H_RES = '0;
   logic [31:0] H_ARGS;
   logic [15:0] H_ACC;
`ifdef PRIM_REC_TIMEOUT_EN
   logic        ERR;
`endif

   always #5 CLK = ~CLK;

   prim_rec_node_p #(
      .WIDTH(16), .NARGS(2), .REC_IDX(1), .CNT_W(16)
`ifdef PRIM_REC_TIMEOUT_EN
      , .TIMEOUT(20)
`endif
   ) dut (
      .CLK(CLK), .RST(RST), .ST(ST), .ARGS(ARGS), .RD(RD), .RES(RES),
      .G_ST(G_ST), .G_RD(G_RD), .G_RES(G_RES),
      .H_ST(H_ST), .H_RD(H_RD), .H_RES(H_RES),
      .H_ARGS(H_ARGS), .H_ACC(H_ACC)
`ifdef PRIM_REC_TIMEOUT_EN
      , .ERR(ERR)
`endif
   );

   int checks = 0;
   int errors = 0;

   int          g_starts = 0;
   int          h_starts = 0;
   logic [15:0] g_val = '0;
   int          h_mode = 0;     // 0: a+1, 1: a*x
   bit          h_hang = 1'b0;
   logic [15:0] slot_log [0:255];
   logic [15:0] xarg_log [0:255];
   logic [15:0] exp_q [$];

   // Child g: drops ready on start, returns g_val after a fixed latency.
   int g_cnt = 0;
   bit g_busy = 1'b0;
   always @(negedge CLK) begin
      if (G_ST) begin
         g_busy = 1'b1; g_cnt = 2; G_RD = 1'b0; g_starts++;
      end else if (g_busy) begin
         if (g_cnt == 0) begin
            G_RES = g_val; G_RD = 1'b1; g_busy = 1'b0;
         end else g_cnt--;
      end
   end

   // Child h: captures its operands at start, variable latency.
   int          h_cnt = 0;
   bit          h_busy = 1'b0;
   logic [15:0] h_acc_cap = '0, h_x_cap = '0;
   always @(negedge CLK) begin
      if (H_ST) begin
         slot_log[h_starts % 256] = H_ARGS[31:16];
         xarg_log[h_starts % 256] = H_ARGS[15:0];
         h_acc_cap = H_ACC; h_x_cap = H_ARGS[15:0];
         h_busy = 1'b1; h_cnt = h_starts % 3; H_RD = 1'b0; h_starts++;
      end else if (h_busy && !h_hang) begin
         if (h_cnt == 0) begin
            H_RES = (h_mode == 1) ? h_acc_cap * h_x_cap : h_acc_cap + 16'd1;
            H_RD = 1'b1; h_busy = 1'b0;
         end else h_cnt--;
      end
   end

   function automatic logic [15:0] f_ref(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] gv, input int hm);
      logic [15:0] a;
      a = gv;
      for (int i = 0; i < int'(y); i++) a = (hm == 1) ? a * x : a + 16'd1;
      return a;
   endfunction

   task automatic wait_rd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         if (RD === 1'b1) begin ok = 1'b1; break; end
         @(negedge CLK);
      end
   endtask

   task automatic do_run(input string nm, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] gv, input int hm, input bit keep_st);
      logic [15:0] exp;
      int gs0, hs0;
      bit ok;
      g_val = gv; h_mode = hm; ARGS = {y, x};
      exp_q.push_back(f_ref(x, y, gv, hm));
      gs0 = g_starts; hs0 = h_starts;
      @(negedge CLK); ST = 1'b1;
      @(negedge CLK);
      checks++;
      if (RD !== 1'b0) begin errors++; $display("FAIL %s_busy: RD=%b want 0", nm, RD); end
      wait_rd(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL %s_timeout: RD never returned", nm); end
      exp = exp_q.pop_front();
      checks++;
      if (RES !== exp) begin errors++; $display("FAIL %s_res: RES=%0d want %0d", nm, RES, exp); end
      checks++;
      if (g_starts - gs0 != 1) begin
         errors++; $display("FAIL %s_gst: g starts=%0d want 1", nm, g_starts - gs0);
      end
      checks++;
      if (h_starts - hs0 != int'(y)) begin
         errors++; $display("FAIL %s_hst: h starts=%0d want %0d", nm, h_starts - hs0, y);
      end
      if (!keep_st) ST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b0; ST = 1'b0;
      repeat (3) @(negedge CLK);
      checks++; if (RD !== 1'b1) begin errors++; $display("FAIL rst_rd: %b want 1", RD); end
      checks++; if (RES !== 16'd0) begin errors++; $display("FAIL rst_res: %0d want 0", RES); end
      checks++; if (G_ST !== 1'b0) begin errors++; $display("FAIL rst_gst: %b want 0", G_ST); end
      checks++; if (H_ST !== 1'b0) begin errors++; $display("FAIL rst_hst: %b want 0", H_ST); end
      checks++; if (H_ACC !== 16'd0) begin errors++; $display("FAIL rst_hacc: %0d want 0", H_ACC); end
`ifdef PRIM_REC_TIMEOUT_EN
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err: %b want 0", ERR); end
`endif
      RST = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_y_zero();
      do_run("y0", 16'd7, 16'd0, 16'd7, 0, 1'b0);
   endtask

   task automatic test_increment();
      int hs0;
      hs0 = h_starts;
      do_run("incr", 16'd5, 16'd3, 16'd5, 0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (slot_log[(hs0 + k) % 256] !== 16'(k)) begin
            errors++;
            $display("FAIL incr_slot%0d: slot=%0d want %0d", k, slot_log[(hs0 + k) % 256], k);
         end
         checks++;
         if (xarg_log[(hs0 + k) % 256] !== 16'd5) begin
            errors++;
            $display("FAIL incr_x%0d: x=%0d want 5", k, xarg_log[(hs0 + k) % 256]);
         end
      end
      do_run("y1", 16'd9, 16'd1, 16'd9, 0, 1'b0);
   endtask

   task automatic test_mul_ignore_st();
      logic [15:0] exp;
      int gs0;
      bit ok;
      g_val = 16'd1; h_mode = 1; ARGS = {16'd10, 16'd2};
      exp_q.push_back(f_ref(16'd2, 16'd10, 16'd1, 1));
      gs0 = g_starts;
      @(negedge CLK); ST = 1'b1;
      repeat (5) @(negedge CLK); ST = 1'b0;
      repeat (3) @(negedge CLK);
      ST = 1'b1;                       // second edge while busy
      ARGS = {16'd0, 16'd99};
      wait_rd(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL mul_timeout: RD never returned"); end
      exp = exp_q.pop_front();
      checks++;
      if (RES !== exp) begin errors++; $display("FAIL mul_res: RES=%0d want %0d", RES, exp); end
      repeat (6) @(negedge CLK);
      checks++;
      if (g_starts - gs0 != 1) begin
         errors++; $display("FAIL mul_restart: g starts=%0d want 1", g_starts - gs0);
      end
      checks++;
      if (RD !== 1'b1 || RES !== 16'd1024) begin
         errors++; $display("FAIL mul_hold: RD=%b RES=%0d want 1/1024", RD, RES);
      end
      ST = 1'b0;
   endtask

   task automatic test_reset_midrun();
      int hs0;
      bit seen;
      g_val = 16'd5; h_mode = 0; ARGS = {16'd3, 16'd5};
      hs0 = h_starts; seen = 1'b0;
      @(negedge CLK); ST = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge CLK);
         if (h_starts == hs0 + 2) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL mid_wait: second h call not seen"); end
      RST = 1'b0; ST = 1'b0;
      @(negedge CLK);
      checks++; if (RD !== 1'b1) begin errors++; $display("FAIL mid_rd: %b want 1", RD); end
      checks++; if (RES !== 16'd0) begin errors++; $display("FAIL mid_res: %0d want 0", RES); end
      checks++; if (H_ACC !== 16'd0) begin errors++; $display("FAIL mid_hacc: %0d want 0", H_ACC); end
      RST = 1'b1;
      repeat (10) @(negedge CLK);
      checks++;
      if (RD !== 1'b1 || RES !== 16'd0) begin
         errors++; $display("FAIL mid_late: RD=%b RES=%0d want 1/0", RD, RES);
      end
      checks++;
      if (h_starts != hs0 + 2) begin
         errors++; $display("FAIL mid_hst: h starts=%0d want 2", h_starts - hs0);
      end
      do_run("fresh", 16'd5, 16'd3, 16'd5, 0, 1'b0);
   endtask

   task automatic test_hold_st();
      int gs0;
      do_run("hold", 16'd4, 16'd2, 16'd4, 0, 1'b1);
      gs0 = g_starts;
      repeat (10) @(negedge CLK);
      checks++;
      if (g_starts != gs0 || RD !== 1'b1) begin
         errors++; $display("FAIL hold_restart: extra g=%0d RD=%b want 0/1", g_starts - gs0, RD);
      end
      ST = 1'b0;
      do_run("rerun", 16'd4, 16'd2, 16'd4, 0, 1'b0);
   endtask

`ifdef PRIM_REC_TIMEOUT_EN
   task automatic test_timeout();
      int hs0, k;
      bit seen, ok;
      h_hang = 1'b1; g_val = 16'd5; h_mode = 0; ARGS = {16'd3, 16'd5};
      hs0 = h_starts; seen = 1'b0;
      @(negedge CLK); ST = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (h_starts == hs0 + 1) begin seen = 1'b1; break; end
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL tmo_hst: no h start seen"); end
      k = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK); k++;
         if (ERR === 1'b1) break;
      end
      checks++; if (k != 20) begin errors++; $display("FAIL tmo_cycles: %0d want 20", k); end
      checks++;
      if (RD !== 1'b1 || RES !== 16'd0) begin
         errors++; $display("FAIL tmo_out: RD=%b RES=%0d want 1/0", RD, RES);
      end
      h_hang = 1'b0; ST = 1'b0; ARGS = {16'd0, 16'd5};
      @(negedge CLK); ST = 1'b1;
      @(negedge CLK);
      checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL tmo_clear: ERR=%b want 0", ERR); end
      wait_rd(ok);
      checks++;
      if (!ok || RES !== 16'd5) begin
         errors++; $display("FAIL tmo_after: RES=%0d want 5", RES);
      end
      ST = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_y_zero();
      test_increment();
      test_mul_ignore_st();
      test_reset_midrun();
      test_hold_st();
`ifdef PRIM_REC_TIMEOUT_EN
      test_timeout();
`endif
      repeat (2) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
